// File: rtl/alu_if.sv
// Operand/opcode request and registered result/flag bundle for alu_core.
// The master drives operands and opcode; the slave (the ALU) returns result and flags.
interface alu_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ALUControl;
    logic [N-1:0] result;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;
    logic         out_valid;

    // Handshake: in_valid=1 at a rising edge launches one operation, with no backpressure.
    // out_valid is high for exactly the one cycle after that edge.
    // Result and flags hold their last value while no new operation arrives.
    modport master (
        output in_valid, a, b, ALUControl,
        input  result, zero, negative, carry, overflow, out_valid
    );

    modport slave (
        input  in_valid, a, b, ALUControl,
        output result, zero, negative, carry, overflow, out_valid
    );
endinterface

// File: rtl/alu_core.sv
// Single-cycle registered ALU: AND/OR/ADD/SUB/PASS-B/NOR with zero, negative,
// carry and overflow flags. Unknown opcodes produce a zero result.
module alu_core #(
    parameter int N = 64
) (
    input logic  clk,
    input logic  reset,
    alu_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic [N:0]   add_ext;
    logic [N:0]   sub_ext;
    logic [N-1:0] nxt_result;
    logic         nxt_zero;
    logic         nxt_negative;
    logic         nxt_carry;
    logic         nxt_overflow;

    logic [N-1:0] result_q;
    logic         zero_q;
    logic         negative_q;
    logic         carry_q;
    logic         overflow_q;
    logic         out_valid_q;

    // Sums are one bit wider so bit N is the carry-out; SUB carry=1 means no borrow.
    always_comb begin
        add_ext = {1'b0, bus.a} + {1'b0, bus.b};
        sub_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + {{N{1'b0}}, 1'b1};
    end

    always_comb begin
        nxt_result   = '0;
        nxt_carry    = 1'b0;
        nxt_overflow = 1'b0;
        case (bus.ALUControl)
            OP_AND:  nxt_result = bus.a & bus.b;
            OP_OR:   nxt_result = bus.a | bus.b;
            OP_ADD: begin
                nxt_result   = add_ext[N-1:0];
                nxt_carry    = add_ext[N];
                nxt_overflow = (bus.a[N-1] == bus.b[N-1]) && (add_ext[N-1] != bus.a[N-1]);
            end
            OP_SUB: begin
                nxt_result   = sub_ext[N-1:0];
                nxt_carry    = sub_ext[N];
                nxt_overflow = (bus.a[N-1] != bus.b[N-1]) && (sub_ext[N-1] != bus.a[N-1]);
            end
            OP_PASS: nxt_result = bus.b;
            OP_NOR:  nxt_result = ~(bus.a | bus.b);
            default: nxt_result = '0;
        endcase
        nxt_zero     = (nxt_result == '0);
        nxt_negative = nxt_result[N-1];
    end

    // Result and flags load only on accepted operations; out_valid tracks in_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            negative_q  <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q   <= nxt_result;
                zero_q     <= nxt_zero;
                negative_q <= nxt_negative;
                carry_q    <= nxt_carry;
                overflow_q <= nxt_overflow;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: every opcode, wrap/overflow corners,
// hold behaviour, illegal opcodes and asynchronous reset.
module tb_alu_core;
    localparam int N = 64;
    localparam logic [N-1:0] ONES = {N{1'b1}};
    localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_if #(.N(N)) bus ();

    alu_core #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Checking
    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [N-1:0] r, input logic z,
                             input logic n, input logic c, input logic v, input logic ov);
        check({tag, ".result"},    bus.result, r);
        check({tag, ".zero"},      N'(bus.zero), N'(z));
        check({tag, ".negative"},  N'(bus.negative), N'(n));
        check({tag, ".carry"},     N'(bus.carry), N'(c));
        check({tag, ".overflow"},  N'(bus.overflow), N'(v));
        check({tag, ".out_valid"}, N'(bus.out_valid), N'(ov));
    endtask

    // Drivers: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge.
    task automatic run_op(input string tag, input logic [3:0] ctl, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] r, input logic z,
                          input logic n, input logic c, input logic v);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.ALUControl = ctl;
        bus.a          = a;
        bus.b          = b;
        @(posedge clk);
        #1;
        check_out(tag, r, z, n, c, v, 1'b1);
    endtask

    task automatic idle_cycle(input string tag, input logic [N-1:0] r, input logic z,
                              input logic n, input logic c, input logic v);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom();
        bus.b        = $urandom();
        @(posedge clk);
        #1;
        check_out(tag, r, z, n, c, v, 1'b0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.ALUControl = 4'b0010;
        bus.a          = 64'd5;
        bus.b          = 64'd6;

        // Reset held across edges with in_valid high must keep reset values.
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_reset_idle", '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back operations, one per cycle.
        run_op("add_m1_2",   4'b0010, ONES, 64'd2, 64'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("and_m1_0",   4'b0000, ONES, 64'd0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("sub_a_a",    4'b0110, 64'hA, 64'hA, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("add_0_m1",   4'b0010, 64'd0, ONES, ONES, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("add_wrap",   4'b0010, ONES, 64'd1, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("or",         4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("pass_b",     4'b0111, 64'h1234, MINN, MINN, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("nor_0_0",    4'b1100, 64'd0, 64'd0, ONES, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("nor_mixed",  4'b1100, 64'hFF00, 64'h00F0, 64'hFFFF_FFFF_FFFF_000F, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sub_borrow", 4'b0110, 64'd0, 64'd1, ONES, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sub_ovf",    4'b0110, MINN, 64'd1, MAXP, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op("ill_0011",   4'b0011, ONES, ONES, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("and_mask",   4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("add_neg_ovf", 4'b0010, MINN, MINN, '0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Hold: no new operation leaves result and flags untouched.
        idle_cycle("hold1", '0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle_cycle("hold2", '0, 1'b1, 1'b0, 1'b1, 1'b1);

        run_op("add_max_1",  4'b0010, MAXP, 64'd1, MINN, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("ill_1111",   4'b1111, MAXP, 64'd1, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("add_5_6",    4'b0010, 64'd5, 64'd6, 64'd11, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with another operation in flight.
        @(negedge clk);
        bus.ALUControl = 4'b0010;
        bus.a          = ONES;
        bus.b          = ONES;
        #2;
        reset = 1'b0;
        #1;
        check_out("async_reset", '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("reset_hold", '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        check_out("no_pulse_after_reset", '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("first_after_reset", 4'b0010, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycle("first_hold", 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
